// File: rtl/sdm_la_core.sv
// Purpose: parametrised look-ahead sigma-delta modulator, one 1-bit DSD symbol per dsd_clk.
// Latency: x_in sampled on edge n drives sdm_out right after edge n (one register).
// Backpressure: none; a symbol is committed every cycle, mute overrides the loop.
module sdm_la_core #(
  parameter int              ORDER      = 6,
  parameter int              DW         = 28,
  parameter int              GW         = 3,
  parameter int              CW         = 20,
  parameter logic [ORDER*CW-1:0] A      = '0,
  parameter int              CSHIFT     = 12,
  parameter int              FS         = 2**26,
  parameter int              RUN_MAX    = 28,
  parameter int              AUTO_RESET = 1
) (
  input  logic                 dsd_clk,
  input  logic                 reset_n,
  input  logic signed [DW-1:0] x_in,
  input  logic                 mute,
  output logic                 sdm_out,
  output logic                 sdm_out_n,
  output logic                 overflow,
  output logic                 sat,
  output logic [4:0]           run_len
);

  // Widest stage, plus headroom so stage sums and +-FS never wrap before clamping.
  localparam int SW = DW + GW * ORDER;
  localparam int WW = ((SW > 33) ? SW : 33) + 2;
  localparam int PW = WW + CW + 4;
  localparam logic signed [WW-1:0] FS_W = WW'(FS);

  typedef enum logic [1:0] {ST_RUN, ST_MUTE, ST_RECOVER} state_t;

  state_t               r_state, w_state_nxt;
  logic signed [WW-1:0] r_s [ORDER];
  logic signed [WW-1:0] w_s_nxt [ORDER];
  logic                 r_out, r_ovf, r_sat;
  logic [4:0]           r_run;
  logic [1:0]           r_m;

  logic signed [WW-1:0] w_cand [2][ORDER];
  logic                 w_clip [2];
  logic signed [PW-1:0] w_abs [2];
  logic                 w_pick, w_bit, w_hit, w_sat_set;
  logic [4:0]           w_inc, w_cnt, w_run_nxt;
  logic [1:0]           w_m_nxt;

  // 2^(width-1) of 1-based stage k; the stage range is [-top, top-1].
  function automatic logic signed [WW-1:0] stage_top(input int k);
    return WW'(1) <<< (DW + GW * k - 1);
  endfunction

  // Evaluate both candidate symbols: saturated integrator update and |cost|.
  always_comb begin
    logic signed [WW-1:0] v_u, v_prev, v_raw, v_top;
    logic signed [PW-1:0] v_acc;
    v_u = '0; v_prev = '0; v_raw = '0; v_top = '0; v_acc = '0;
    for (int b = 0; b < 2; b++) begin
      w_clip[b] = 1'b0;
      v_acc     = '0;
      v_u       = WW'(x_in) + ((b == 1) ? -FS_W : FS_W);
      v_prev    = '0;
      for (int k = 0; k < ORDER; k++) begin
        // Every stage adds the old value of its predecessor (first stage adds u).
        v_raw  = r_s[k] + ((k == 0) ? v_u : v_prev);
        v_prev = r_s[k];
        v_top  = stage_top(k + 1);
        if (v_raw > v_top - 1) begin
          v_raw     = v_top - 1;
          w_clip[b] = 1'b1;
        end else if (v_raw < -v_top) begin
          v_raw     = -v_top;
          w_clip[b] = 1'b1;
        end
        w_cand[b][k] = v_raw;
        v_acc = v_acc + PW'($signed(A[k*CW +: CW])) * PW'(v_raw);
      end
      v_acc    = v_acc >>> CSHIFT;
      w_abs[b] = (v_acc < 0) ? -v_acc : v_acc;
    end
  end

  // Ties favour the '1' symbol.
  assign w_pick = (w_abs[1] <= w_abs[0]);

  // Next-state, output bit, run counter; mute has priority over everything.
  always_comb begin
    w_state_nxt = ST_RUN;
    w_bit       = w_pick;
    w_m_nxt     = 2'd0;
    w_sat_set   = 1'b0;
    for (int k = 0; k < ORDER; k++) w_s_nxt[k] = w_cand[w_pick][k];
    if (mute) begin
      w_state_nxt = ST_MUTE;
      w_bit       = r_m[1];
      w_m_nxt     = r_m + 2'd1;
      for (int k = 0; k < ORDER; k++) w_s_nxt[k] = '0;
    end else if (r_state == ST_RECOVER) begin
      w_state_nxt = ST_RUN;
      w_bit       = ~r_out;
      for (int k = 0; k < ORDER; k++) w_s_nxt[k] = '0;
    end else begin
      w_sat_set = w_clip[w_pick];
    end
    w_inc     = (r_run == 5'd31) ? 5'd31 : r_run + 5'd1;
    w_cnt     = (w_bit == r_out) ? w_inc : 5'd1;
    w_hit     = (w_cnt == 5'(RUN_MAX)) && (r_run != 5'(RUN_MAX));
    w_run_nxt = mute ? 5'd0 : w_cnt;
    if (!mute && r_state != ST_RECOVER && w_hit && AUTO_RESET != 0)
      w_state_nxt = ST_RECOVER;
  end

  // State register; asynchronous reset to an idle modulator.
  always_ff @(posedge dsd_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      for (int k = 0; k < ORDER; k++) r_s[k] <= '0;
      r_out   <= 1'b0;
      r_ovf   <= 1'b0;
      r_sat   <= 1'b0;
      r_run   <= 5'd0;
      r_m     <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      for (int k = 0; k < ORDER; k++) r_s[k] <= w_s_nxt[k];
      r_out   <= w_bit;
      r_ovf   <= r_ovf | w_hit;
      r_sat   <= r_sat | w_sat_set;
      r_run   <= w_run_nxt;
      r_m     <= w_m_nxt;
    end
  end

  assign sdm_out   = r_out;
  assign sdm_out_n = ~r_out;
  assign overflow  = r_ovf;
  assign sat       = r_sat;
  assign run_len   = r_run;

endmodule
